// File: rtl/sr_flag_arbiter.sv
// Round-robin sequencer sharing one SR latch bank among NREQ requesters.
// Drives s/r, a one-hot enable through setup/pulse/release, and keeps a registered shadow of the flags.
module sr_flag_arbiter #(
   parameter int NREQ      = 4,
   parameter int NFLAG     = 8,
   parameter int AW        = 3,
   parameter int PULSE_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    op,
   input  logic [NREQ*AW-1:0] idx,
   output logic [NREQ-1:0]    gnt,
   output logic               done,
   output logic               busy,
   output logic               s,
   output logic               r,
   output logic [NFLAG-1:0]   en,
   output logic [NFLAG-1:0]   flags
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, RELEASE} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win_id;
   logic            win_op;
   logic [AW-1:0]   win_idx;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   pick_id;
   logic            pick_vld;
   logic [NREQ-1:0] win_oh;
   logic [NFLAG-1:0] fl_oh;

   // Walk from the highest offset down so the nearest requester above ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NREQ]) begin
            pick_vld = 1'b1;
            pick_id  = IW'((int'(ptr) + i) % NREQ);
         end
      end
   end

   // An index outside the bank decodes to no enable bit, so en and flags stay untouched.
   always_comb begin
      win_oh = '0;
      fl_oh  = '0;
      for (int q = 0; q < NREQ; q++)
         win_oh[q] = (win_id == IW'(q));
      for (int f = 0; f < NFLAG; f++)
         fl_oh[f] = (win_idx == AW'(f));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         win_id  <= '0;
         win_op  <= 1'b0;
         win_idx <= '0;
         cnt     <= '0;
         gnt     <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         s       <= 1'b0;
         r       <= 1'b0;
         en      <= '0;
         flags   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state   <= SETUP;
                  win_id  <= pick_id;
                  win_op  <= op[pick_id];
                  win_idx <= idx[int'(pick_id)*AW +: AW];
                  s       <= op[pick_id];
                  r       <= ~op[pick_id];
                  busy    <= 1'b1;
               end
            end
            SETUP: begin
               state <= PULSE;
               cnt   <= CW'(PULSE_CYC - 1);
               en    <= fl_oh;
            end
            PULSE: begin
               if (cnt == '0) begin
                  state <= RELEASE;
                  en    <= '0;
                  gnt   <= win_oh;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RELEASE: begin
               state <= IDLE;
               gnt   <= '0;
               done  <= 1'b0;
               busy  <= 1'b0;
               s     <= 1'b0;
               r     <= 1'b0;
               flags <= (flags & ~fl_oh) | (fl_oh & {NFLAG{win_op}});
               ptr   <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level round-robin / flag-array model.
module tb_sr_flag_arbiter;
   localparam int NREQ = 4, NFLAG = 8, AW = 4, PC = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req, op, gnt;
   logic [NREQ*AW-1:0] idx;
   logic               done, busy, s, r;
   logic [NFLAG-1:0]   en, flags;

   int checks = 0, errors = 0;
   int m_ptr = 0;
   logic [NFLAG-1:0] m_flags = '0;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .AW(AW), .PULSE_CYC(PC)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .gnt(gnt), .done(done),
      .busy(busy), .s(s), .r(r), .en(en), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; req = '0; op = '0; idx = '0;
      repeat (2) @(negedge clk);
      checks++; if (gnt !== '0 || done !== 1'b0) begin errors++; $display("FAIL reset_gnt gnt=%b done=%b want 0", gnt, done); end
      checks++; if (busy !== 1'b0 || s !== 1'b0 || r !== 1'b0) begin errors++; $display("FAIL reset_ctl busy=%b s=%b r=%b want 0", busy, s, r); end
      checks++; if (en !== '0 || flags !== 8'h00) begin errors++; $display("FAIL reset_bank en=%h flags=%h want 00", en, flags); end
      rst = 1'b0;
      m_ptr = 0; m_flags = '0;
   endtask

   task automatic test_single_set();
      req = 4'b0100; op = 4'b0100; idx = '0; idx[2*AW +: AW] = 4'd5;
      for (int c = 1; c <= PC + 3; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++; if (s !== 1'b1 || r !== 1'b0 || en !== '0 || busy !== 1'b1) begin errors++; $display("FAIL set_setup s=%b r=%b en=%h busy=%b want 1 0 00 1", s, r, en, busy); end
            req = '0;
         end
         if (c == 2 || c == 3) begin
            checks++; if (en !== 8'h20 || s !== 1'b1) begin errors++; $display("FAIL set_pulse c=%0d en=%h s=%b want 20 1", c, en, s); end
         end
         if (c == 4) begin
            checks++; if (gnt !== 4'b0100 || done !== 1'b1 || en !== '0 || s !== 1'b1) begin errors++; $display("FAIL set_release gnt=%b done=%b en=%h s=%b want 0100 1 00 1", gnt, done, en, s); end
         end
         if (c == 5) begin
            checks++; if (flags !== 8'h20 || busy !== 1'b0 || s !== 1'b0) begin errors++; $display("FAIL set_flags flags=%h busy=%b s=%b want 20 0 0", flags, busy, s); end
         end
      end
      m_ptr = 3; m_flags = 8'h20;
   endtask

   task automatic test_reset_op();
      req = 4'b0010; op = 4'b0000; idx = '0; idx[1*AW +: AW] = 4'd5;
      for (int c = 1; c <= PC + 3; c++) begin
         @(negedge clk);
         req = '0;
         checks++; if ((s & r) !== 1'b0 || !$onehot0(en)) begin errors++; $display("FAIL rop_safety c=%0d s=%b r=%b en=%h", c, s, r, en); end
         checks++; if (en !== ((c == 2 || c == 3) ? 8'h20 : 8'h00)) begin errors++; $display("FAIL rop_en c=%0d en=%h", c, en); end
         if (c == 1) begin
            checks++; if (r !== 1'b1 || s !== 1'b0) begin errors++; $display("FAIL rop_lines s=%b r=%b want 0 1", s, r); end
         end
         if (c == 4) begin
            checks++; if (gnt !== 4'b0010 || done !== 1'b1) begin errors++; $display("FAIL rop_gnt gnt=%b done=%b want 0010 1", gnt, done); end
         end
         if (c == 5) begin
            checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rop_flags flags=%h want 00", flags); end
         end
      end
      m_ptr = 2; m_flags = 8'h00;
   endtask

   task automatic test_contention();
      int ngnt;
      logic [NREQ-1:0] eg;
      ngnt = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111; op = 4'b1111;
      for (int k = 0; k < NREQ; k++) idx[k*AW +: AW] = AW'(k);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         eg = (c % 5 == 4) ? (NREQ'(1) << ((c / 5) % NREQ)) : '0;
         if (gnt !== '0) ngnt++;
         checks++; if (gnt !== eg || done !== (c % 5 == 4)) begin errors++; $display("FAIL cont_gnt c=%0d gnt=%b done=%b want %b", c, gnt, done, eg); end
         checks++; if ((s & r) !== 1'b0) begin errors++; $display("FAIL cont_safety c=%0d s=%b r=%b", c, s, r); end
         if (c == 20) begin
            checks++; if (flags !== 8'h0F) begin errors++; $display("FAIL cont_flags flags=%h want 0f", flags); end
         end
         if (c == 25) req = '0;
      end
      checks++; if (ngnt != 5) begin errors++; $display("FAIL cont_count grants=%0d want 5", ngnt); end
      m_ptr = 1; m_flags = 8'h0F;
   endtask

   task automatic test_mid_pulse_reset();
      logic       op0;
      logic [3:0] idx0;
      req = 4'b1000; op = 4'b0000; idx[3*AW +: AW] = 4'd2;
      repeat (2) @(negedge clk);
      checks++; if (en !== 8'h04) begin errors++; $display("FAIL mpr_pulse en=%h want 04", en); end
      rst = 1'b1;
      #1;
      checks++; if (en !== '0 || s !== 1'b0 || r !== 1'b0 || flags !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mpr_async en=%h s=%b r=%b flags=%h busy=%b want all 0", en, s, r, flags, busy); end
      @(negedge clk);
      op0 = 1'($urandom); idx0 = 4'($urandom_range(0, NFLAG - 1));
      req = 4'b1111; op = 4'($urandom); op[0] = op0; idx = 16'($urandom); idx[0 +: AW] = idx0;
      @(negedge clk);
      rst = 1'b0;
      m_flags = '0;
      for (int c = 1; c <= PC + 3; c++) begin
         @(negedge clk);
         req = '0;
         if (c == 4) begin
            checks++; if (gnt !== 4'b0001 || done !== 1'b1) begin errors++; $display("FAIL mpr_winner gnt=%b want 0001", gnt); end
         end
      end
      m_flags[idx0] = op0;
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL mpr_flags flags=%h want %h", flags, m_flags); end
      m_ptr = 1;
   endtask

   task automatic test_out_of_range();
      req = 4'b0100; op = 4'b0100; idx[2*AW +: AW] = 4'd9;
      for (int c = 1; c <= PC + 3; c++) begin
         @(negedge clk);
         req = '0;
         checks++; if (en !== '0) begin errors++; $display("FAIL oor_en c=%0d en=%h want 00", c, en); end
         if (c == 4) begin
            checks++; if (gnt !== 4'b0100 || done !== 1'b1) begin errors++; $display("FAIL oor_gnt gnt=%b done=%b want 0100 1", gnt, done); end
         end
         if (c == 5) begin
            checks++; if (flags !== m_flags || busy !== 1'b0) begin errors++; $display("FAIL oor_flags flags=%h busy=%b want %h 0", flags, busy, m_flags); end
         end
      end
      m_ptr = 3;
   endtask

   // Requests stay pending until granted; the winner is the first pending id at or above the model pointer.
   task automatic test_random(input int ntx);
      bit              pend [NREQ];
      logic [NREQ-1:0] pop;
      int              pidx [NREQ];
      int              w, n;
      logic [NFLAG-1:0] exp_en, ee;
      logic [NREQ-1:0]  eg;
      pop = '0;
      for (int k = 0; k < NREQ; k++) begin pend[k] = 1'b0; pidx[k] = 0; end
      for (int t = 0; t < ntx; t++) begin
         n = 0;
         for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && $urandom_range(0, 2) != 0) begin
               pend[k] = 1'b1; pop[k] = 1'($urandom); pidx[k] = $urandom_range(0, NFLAG + 3);
            end
            if (pend[k]) n++;
         end
         if (n == 0) begin
            w = $urandom_range(0, NREQ - 1);
            pend[w] = 1'b1; pop[w] = 1'($urandom); pidx[w] = $urandom_range(0, NFLAG - 1);
         end
         for (int k = 0; k < NREQ; k++) begin
            req[k] = pend[k]; op[k] = pop[k]; idx[k*AW +: AW] = AW'(pidx[k]);
         end
         w = -1;
         for (int i = 0; i < NREQ; i++)
            if (w < 0 && pend[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
         exp_en = (pidx[w] < NFLAG) ? (NFLAG'(1) << pidx[w]) : '0;
         for (int c = 1; c <= PC + 3; c++) begin
            @(negedge clk);
            ee = (c >= 2 && c <= PC + 1) ? exp_en : '0;
            eg = (c == PC + 2) ? (NREQ'(1) << w) : '0;
            checks++; if ((s & r) !== 1'b0 || en !== ee) begin errors++; $display("FAIL rnd_en t=%0d c=%0d en=%h s=%b r=%b want en %h", t, c, en, s, r, ee); end
            checks++; if (gnt !== eg || done !== (c == PC + 2)) begin errors++; $display("FAIL rnd_gnt t=%0d c=%0d gnt=%b done=%b want %b", t, c, gnt, done, eg); end
            if (c <= PC + 2) begin
               checks++; if (busy !== 1'b1 || s !== pop[w] || r !== ~pop[w]) begin errors++; $display("FAIL rnd_lines t=%0d c=%0d busy=%b s=%b r=%b op=%b", t, c, busy, s, r, pop[w]); end
            end else begin
               if (pidx[w] < NFLAG) m_flags[pidx[w]] = pop[w];
               checks++; if (flags !== m_flags || busy !== 1'b0) begin errors++; $display("FAIL rnd_flags t=%0d flags=%h busy=%b want %h 0", t, flags, busy, m_flags); end
            end
            if (c <= PC + 1) begin
               req[w] = 1'($urandom); op[w] = 1'($urandom); idx[w*AW +: AW] = AW'($urandom);
            end
         end
         pend[w] = 1'b0;
         m_ptr = (w + 1) % NREQ;
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single_set();
      test_reset_op();
      test_contention();
      test_mid_pulse_reset();
      test_out_of_range();
      test_random(60);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
